// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: op codes, FSM states and operand-sign decode for the RV32M MDU.
package mdu_unit_pkg;

  localparam int MDU_XLEN = 32;

  // RV32M funct3 encoding; all eight values are legal.
  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM,    MDU_REMU
  } mdu_op_t;

  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_DONE} mdu_state_t;

  // rs1 is treated as signed
  function automatic logic op_sa(mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic op_sb(mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: request/response valid-ready handshake between execute stage and MDU.
interface mdu_unit_if #(parameter int XLEN = 32);
  import mdu_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  mdu_op_t         req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: one restoring-division step (shift in next dividend bit, trial subtract).
// rem/quo are the partial remainder and the dividend/quotient shift register.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  // Trial subtract; the top bit of diff is the borrow, i.e. "restore".
  always_comb begin
    shl     = {rem, quo[XLEN-1]};
    diff    = shl - {1'b0, dvsr};
    rem_nxt = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
  end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle RV32M multiply/divide unit beside the ALU.
// Iterative ops: XLEN CALC cycles, then one DONE cycle that applies the sign fix
// and raises resp_valid. Div-by-zero and signed overflow skip CALC.
// Optional MDU_FAST_MUL_EN: multiplies use a combinational 2*XLEN multiplier
// and skip CALC; without it no hardware multiplier is inferred.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  mdu_unit_if.slave  io,
  output logic       busy
);
  localparam int CW = $clog2(XLEN);

  mdu_state_t      state;
  mdu_op_t         op;
  logic [XLEN-1:0] hi, lo, dvsr;   // {hi,lo}: product, or remainder/quotient
  logic            neg;            // negate the selected result in the final step
  logic [CW-1:0]   cnt;

  logic            a_neg, b_neg, div_zero, ovf, fast_mul;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   msum;
  logic [XLEN-1:0] mhi, mlo, dhi, dlo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] res;

  assign busy         = (state != MDU_IDLE);
  assign io.req_ready = (state == MDU_IDLE) && !flush;

  // Operand magnitudes and single-cycle special cases at the request port
  always_comb begin
    a_neg    = op_sa(io.req_op) & io.req_a[XLEN-1];
    b_neg    = op_sb(io.req_op) & io.req_b[XLEN-1];
    a_mag    = a_neg ? -io.req_a : io.req_a;
    b_mag    = b_neg ? -io.req_b : io.req_b;
    div_zero = io.req_op[2] && (io.req_b == '0);
    ovf      = ((io.req_op == MDU_DIV) || (io.req_op == MDU_REM)) &&
               (io.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (io.req_b == '1);
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  // Sign-extended operands; the low 2*XLEN bits of the product are exact
  always_comb begin
    fa       = {{XLEN{op_sa(io.req_op) & io.req_a[XLEN-1]}}, io.req_a};
    fb       = {{XLEN{op_sb(io.req_op) & io.req_b[XLEN-1]}}, io.req_b};
    fprod    = fa * fb;
    fast_mul = ~io.req_op[2];
  end
`else
  assign fast_mul = 1'b0;
`endif

  // Shift-add multiply step: add multiplicand on lo[0], shift {carry,hi,lo} right
  always_comb begin
    msum = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : {(XLEN+1){1'b0}});
    mhi  = msum[XLEN:1];
    mlo  = {msum[0], lo[XLEN-1:1]};
  end

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .rem     (hi),
    .quo     (lo),
    .dvsr    (dvsr),
    .rem_nxt (dhi),
    .quo_nxt (dlo)
  );

  // Final step: sign fix and half/quotient/remainder select
  always_comb begin
    prod_s = neg ? -{hi, lo} : {hi, lo};
    res    = '0;
    case (op)
      MDU_MUL:                       res = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:             res = neg ? -lo : lo;
      default:                       res = neg ? -hi : hi;
    endcase
  end

  // Control FSM with registered response; flush beats everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MDU_IDLE;
      op            <= MDU_MUL;
      hi            <= '0;
      lo            <= '0;
      dvsr          <= '0;
      neg           <= 1'b0;
      cnt           <= '0;
      io.resp_valid <= 1'b0;
      io.resp_data  <= '0;
    end else if (flush) begin
      state         <= MDU_IDLE;
      io.resp_valid <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: if (io.req_valid) begin
          op  <= io.req_op;
          cnt <= '0;
          neg <= 1'b0;
          if (div_zero) begin
            hi    <= io.req_a;
            lo    <= '1;
            state <= MDU_DONE;
          end else if (ovf) begin
            hi    <= '0;
            lo    <= {1'b1, {(XLEN-1){1'b0}}};
            state <= MDU_DONE;
          end else if (fast_mul) begin
`ifdef MDU_FAST_MUL_EN
            hi    <= fprod[2*XLEN-1:XLEN];
            lo    <= fprod[XLEN-1:0];
`endif
            state <= MDU_DONE;
          end else begin
            hi    <= '0;
            lo    <= a_mag;
            dvsr  <= b_mag;
            neg   <= (io.req_op == MDU_REM) ? a_neg : (a_neg ^ b_neg);
            state <= MDU_CALC;
          end
        end
        MDU_CALC: begin
          hi  <= op[2] ? dhi : mhi;
          lo  <= op[2] ? dlo : mlo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) state <= MDU_DONE;
        end
        MDU_DONE: begin
          if (!io.resp_valid) begin
            io.resp_data  <= res;
            io.resp_valid <= 1'b1;
          end else if (io.resp_ready) begin
            io.resp_valid <= 1'b0;
            state         <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule
